// File: rtl/dff_chain_pkg.sv
// Shared types and defaults for the serial flip-flop chain loader.
package dff_chain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/dff_chain_loader.sv
// Shifts a parallel word into an external flop chain, capturing the old contents.
// state  | meaning
// IDLE   | ready for a word, outputs quiet, rd_data held
// SHIFT  | WIDTH cycles of shift_en, new bits out / old bits in
// UPDATE | one-cycle update + rd_valid strobe
module dff_chain_loader
    import dff_chain_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             shift_en,
    output logic             shift_d,
    input  logic             chain_so,
    output logic             update,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] load_word;
    logic [CNT_W-1:0] cnt;

    // The first bit to leave is always sreg[WIDTH-1], so LSB-first words are mirrored on load.
    always_comb begin
        load_word = in_data;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                load_word[i] = in_data[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cap   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= load_word;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    cap  <= {cap[WIDTH-2:0], chain_so};
                    if (cnt == CNT_LAST) begin
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UPDATE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; in_ready is also held low during reset.
    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);
    assign shift_en = (state == SHIFT);
    assign shift_d  = (state == SHIFT) && sreg[WIDTH-1];
    assign update   = (state == UPDATE);
    assign rd_valid = (state == UPDATE);
    assign rd_data  = cap;

endmodule

// File: tb/tb_dff_chain_loader.sv
// Self-checking bench: two loaders (MSB-first and LSB-first) each driving a modelled flop chain.
module tb_dff_chain_loader;
    import dff_chain_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vld0 = 1'b0, vld1 = 1'b0;
    logic [W-1:0] dat0 = '0, dat1 = '0;
    logic         rdy0, rdy1, se0, se1, sd0, sd1, so0, so1;
    logic         upd0, upd1, rv0, rv1, bsy0, bsy1;
    logic [W-1:0] rd0, rd1;
    logic [W-1:0] chain0 = '0, chain1 = '0;

    int total = 0, bad = 0;
    int cyc = 0, upd_cnt0 = 0, acc_cnt0 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (upd0) upd_cnt0 <= upd_cnt0 + 1;
        if (vld0 && rdy0) acc_cnt0 <= acc_cnt0 + 1;
    end

    // Chain models: chainN[0] is the first flop, chainN[W-1] drives scan-out.
    always @(posedge clk) if (se0) chain0 <= {chain0[W-2:0], sd0};
    always @(posedge clk) if (se1) chain1 <= {chain1[W-2:0], sd1};
    assign so0 = chain0[W-1];
    assign so1 = chain1[W-1];

    dff_chain_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(rdy0), .in_data(dat0),
        .shift_en(se0), .shift_d(sd0), .chain_so(so0), .update(upd0),
        .rd_data(rd0), .rd_valid(rv0), .busy(bsy0));

    dff_chain_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(rdy1), .in_data(dat1),
        .shift_en(se1), .shift_d(sd1), .chain_so(so1), .update(upd1),
        .rd_data(rd1), .rd_valid(rv1), .busy(bsy1));

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] exp_rd;
        logic [W-1:0] exp_chain;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    // Called between a falling and a rising edge; returns at the falling edge of cycle W+2.
    task automatic xfer(input bit s, input logic [W-1:0] d, input bit hold,
                        output logic [W-1:0] rd, output logic [W-1:0] seq, output int t_acc);
        int n = 0;
        while (!(s ? rdy1 : rdy0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(s ? rdy1 : rdy0), 1);
        if (s) begin vld1 = 1'b1; dat1 = d; end
        else   begin vld0 = 1'b1; dat0 = d; end
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (!hold) begin
            if (s) vld1 = 1'b0;
            else   vld0 = 1'b0;
        end
        seq = '0;
        rd  = '0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k <= W) begin
                seq = {seq[W-2:0], (s ? sd1 : sd0)};
                chk("shift_en", 32'(s ? se1 : se0), 1);
                chk("update_early", 32'(s ? upd1 : upd0), 0);
            end else if (k == W + 1) begin
                chk("update", 32'(s ? upd1 : upd0), 1);
                chk("rd_valid", 32'(s ? rv1 : rv0), 1);
                chk("shift_en_off", 32'(s ? se1 : se0), 0);
                rd = s ? rd1 : rd0;
            end else begin
                chk("ready_back", 32'(s ? rdy1 : rdy0), 1);
                chk("busy_idle", 32'(s ? bsy1 : bsy0), 0);
                chk("update_off", 32'(s ? upd1 : upd0), 0);
            end
            if (k <= W + 1) chk("ready_busy", 32'(s ? rdy1 : rdy0), 0);
        end
    endtask

    initial begin
        vec_t         tbl[4];
        logic [W-1:0] m_chain[2];
        logic [W-1:0] rd, seq, partial;
        int           t_acc, t_prev, acc_before, upd_before;

        tbl[0] = '{8'hA5, 8'h00, 8'hA5};
        tbl[1] = '{8'h3C, 8'hA5, 8'h3C};
        tbl[2] = '{8'hFF, 8'h3C, 8'hFF};
        tbl[3] = '{8'h00, 8'hFF, 8'h00};
        m_chain[0] = '0;
        m_chain[1] = '0;

        // Reset and idle behaviour.
        #12;
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_busy", 32'(bsy0), 0);
        chk("rst_rd", 32'(rd0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", 32'(rdy0), 1);
        chk("idle_busy", 32'(bsy0), 0);
        chk("idle_rd", 32'(rd0), 0);
        repeat (5) @(negedge clk);
        chk("idle_no_update", 32'(upd_cnt0), 0);
        chk("idle_shift_d", 32'(sd0), 0);

        // Table of back-to-back loads into the MSB-first chain.
        t_prev = 0;
        foreach (tbl[i]) begin
            xfer(1'b0, tbl[i].d, 1'b0, rd, seq, t_acc);
            chk("tbl_shift_d_seq", 32'(seq), 32'(tbl[i].exp_chain));
            chk("tbl_rd_data", 32'(rd), 32'(tbl[i].exp_rd));
            chk("tbl_chain", 32'(chain0), 32'(tbl[i].exp_chain));
            if (i > 0) chk("tbl_accept_gap", 32'(t_acc - t_prev), W + 2);
            t_prev = t_acc;
        end
        m_chain[0] = tbl[3].exp_chain;

        // LSB-first: only the first shifted bit is 1 and it ends at the last flop.
        xfer(1'b1, 8'h01, 1'b0, rd, seq, t_acc);
        chk("lsb_shift_d_seq", 32'(seq), 32'h80);
        chk("lsb_chain", 32'(chain1), 32'h80);
        chk("lsb_rd_data", 32'(rd), 0);
        m_chain[1] = 8'h80;

        // in_valid held high across a whole transfer.
        acc_before = acc_cnt0;
        xfer(1'b0, 8'h96, 1'b1, rd, seq, t_prev);
        xfer(1'b0, 8'h69, 1'b0, rd, seq, t_acc);
        chk("hold_accept_gap", 32'(t_acc - t_prev), W + 2);
        chk("hold_accept_count", 32'(acc_cnt0 - acc_before), 2);
        chk("hold_rd_data", 32'(rd), 32'h96);
        chk("hold_chain", 32'(chain0), 32'h69);
        m_chain[0] = 8'h69;

        // Reset in cycle 4 of a shift: three bits of C3 already entered the chain.
        upd_before = upd_cnt0;
        vld0 = 1'b1;
        dat0 = 8'hC3;
        @(posedge clk);
        #1;
        vld0 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_shift_en", 32'(se0), 0);
        chk("abort_shift_d", 32'(sd0), 0);
        chk("abort_update", 32'(upd0), 0);
        chk("abort_rd_valid", 32'(rv0), 0);
        chk("abort_busy", 32'(bsy0), 0);
        chk("abort_ready", 32'(rdy0), 0);
        chk("abort_rd_data", 32'(rd0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        chk("abort_no_update", 32'(upd_cnt0 - upd_before), 0);
        partial = W'((32'(m_chain[0]) << 3) | (32'(8'hC3) >> (W - 3)));
        chk("abort_partial_chain", 32'(chain0), 32'(partial));
        xfer(1'b0, 8'h5A, 1'b0, rd, seq, t_acc);
        chk("reload_rd_data", 32'(rd), 32'(partial));
        chk("reload_chain", 32'(chain0), 32'h5A);
        m_chain[0] = 8'h5A;

        // Random words into either chain against the "old contents out, new word in" model.
        for (int it = 0; it < 24; it++) begin
            bit           s;
            logic [W-1:0] d, exp_new;
            s = 1'($urandom_range(0, 1));
            d = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            exp_new = s ? rev(d) : d;
            xfer(s, d, 1'b0, rd, seq, t_acc);
            chk("rnd_rd_data", 32'(rd), 32'(m_chain[s]));
            chk("rnd_shift_d_seq", 32'(seq), 32'(exp_new));
            chk("rnd_chain", 32'(s ? chain1 : chain0), 32'(exp_new));
            m_chain[s] = exp_new;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
